// File: rtl/osc_freq_monitor.sv
// -----------------------------------------------------------------------------
// osc_freq_monitor
//
// Fabric-side frequency monitor for the 1 MHz RC oscillator fabric output.
// OSC_IN is synchronised into the CLK domain, its rising edges are counted
// over a fixed window of WINDOW_CYCLES clock cycles, and the result is
// published together with range / loss flags and a fault indication.
//
// Parameters:
//   SYNC_STAGES   synchroniser depth on OSC_IN (2..4)
//   WINDOW_CYCLES CLK cycles per measurement window (>= 4)
//   CNT_W         width of the edge counter and COUNT
//   MIN_COUNT     lowest in-range edge count (inclusive)
//   MAX_COUNT     highest in-range edge count (inclusive)
//
// Ports:
//   CLK          fabric clock, rising edge
//   RESET        synchronous active-high reset
//   OSC_IN       oscillator output, asynchronous to CLK
//   EN           enables continuous measurement
//   CLR_FAULT    single-cycle clear for a sticky FAULT
//   COUNT        edge count of the last completed window
//   COUNT_VALID  one-cycle pulse when COUNT updates
//   FREQ_OK      last count within [MIN_COUNT, MAX_COUNT]
//   OSC_LOST     last count was zero
//   FAULT        fault indication
//   state_dbg    current FSM state (0 IDLE, 1 MEASURE, 2 EVAL)
//
// Build option:
//   OSC_MON_STICKY_FAULT_EN  when defined, FAULT latches on an out-of-range
//                            or zero count and clears only via CLR_FAULT.
//                            When undefined, FAULT mirrors !FREQ_OK at
//                            every evaluation and CLR_FAULT is ignored.
// -----------------------------------------------------------------------------
module osc_freq_monitor #(
   parameter int SYNC_STAGES   = 2,
   parameter int WINDOW_CYCLES = 5000,
   parameter int CNT_W         = 16,
   parameter int MIN_COUNT     = 95,
   parameter int MAX_COUNT     = 105
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             OSC_IN,
   input  logic             EN,
   input  logic             CLR_FAULT,
   output logic [CNT_W-1:0] COUNT,
   output logic             COUNT_VALID,
   output logic             FREQ_OK,
   output logic             OSC_LOST,
   output logic             FAULT,
   output logic [1:0]       state_dbg
);

   localparam int WIN_W = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_SAT  = '1;
   localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(MIN_COUNT);
   localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_COUNT);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MEASURE = 2'd1,
      EVAL    = 2'd2
   } state_t;

   state_t             state;
   logic [SYNC_STAGES-1:0] sync_q;
   logic               prev_q;
   logic               rise;
   logic [WIN_W-1:0]   win_cnt;
   logic [CNT_W-1:0]   edge_cnt;
   logic               in_range;
   logic               is_zero;

   // OSC_IN is treated as plain data: a shift-register synchroniser followed
   // by one extra flop that holds the previous synchronised value.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], OSC_IN};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign rise     = sync_q[SYNC_STAGES-1] & ~prev_q;
   assign in_range = (edge_cnt >= MIN_C) && (edge_cnt <= MAX_C);
   assign is_zero  = (edge_cnt == '0);

   assign state_dbg = state;

`ifndef OSC_MON_STICKY_FAULT_EN
   // CLR_FAULT has no function when FAULT is not sticky.
   logic clr_fault_unused;
   assign clr_fault_unused = CLR_FAULT;
`endif

   // Output protocol: there is no back-pressure. COUNT_VALID is a one-cycle
   // pulse registered together with COUNT, FREQ_OK, OSC_LOST and FAULT; the
   // consumer must capture on that cycle. Between pulses all result outputs
   // hold, and an aborted window (EN low in MEASURE) produces no pulse.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state       <= IDLE;
         win_cnt     <= '0;
         edge_cnt    <= '0;
         COUNT       <= '0;
         COUNT_VALID <= 1'b0;
         FREQ_OK     <= 1'b0;
         OSC_LOST    <= 1'b0;
         FAULT       <= 1'b0;
      end else begin
         COUNT_VALID <= 1'b0;
`ifdef OSC_MON_STICKY_FAULT_EN
         // A set in EVAL below is assigned later, so it overrides this clear.
         if (CLR_FAULT) begin
            FAULT <= 1'b0;
         end
`endif
         case (state)
            IDLE: begin
               if (EN) begin
                  state    <= MEASURE;
                  win_cnt  <= '0;
                  edge_cnt <= '0;
               end
            end

            MEASURE: begin
               if (!EN) begin
                  // Abort: results from the previous window are left intact.
                  state <= IDLE;
               end else begin
                  win_cnt <= win_cnt + 1'b1;
                  if (rise && (edge_cnt != CNT_SAT)) begin
                     edge_cnt <= edge_cnt + 1'b1;
                  end
                  if (win_cnt == WIN_LAST) begin
                     state <= EVAL;
                  end
               end
            end

            EVAL: begin
               // An edge detected in this cycle is deliberately not counted.
               COUNT       <= edge_cnt;
               COUNT_VALID <= 1'b1;
               FREQ_OK     <= in_range;
               OSC_LOST    <= is_zero;
`ifdef OSC_MON_STICKY_FAULT_EN
               if (!in_range || is_zero) begin
                  FAULT <= 1'b1;
               end
`else
               FAULT <= !in_range;
`endif
               win_cnt  <= '0;
               edge_cnt <= '0;
               state    <= EN ? MEASURE : IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
